// File: rtl/input_ctrl_keypad.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce and a
// CPU-readable status word (valid / overrun / key code).
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif

module input_ctrl_keypad #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    key_row,
    output logic [3:0]                    key_col,
    input  logic                          io_rd_en,
    output logic [`IO_BUS_WIDTH_DATA-1:0] io_rd_data,
    output logic                          key_valid,
    output logic [3:0]                    key_code,
    output logic                          key_down,
    output logic [1:0]                    o_dbg_state
);

    localparam int         DIV_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;
    typedef enum logic [1:0] {C_NONE, C_ONE, C_MULTI} cls_t;

    logic             r_run;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [15:0]      r_map;
    logic             r_frame_done;
    cls_t             r_cls;
    logic [3:0]       r_cls_code;
    state_t           r_state;
    logic [3:0]       r_match_cnt;
    logic [3:0]       r_rel_cnt;
    logic [3:0]       r_cand;
    logic             r_key_valid;
    logic             r_overrun;
    logic [3:0]       r_key_code;
    logic             r_key_down;

    logic             w_sample;
    logic [15:0]      w_map;
    logic [4:0]       w_nbits;
    logic [3:0]       w_code;
    state_t           w_state_nx;
    logic [3:0]       w_match_nx;
    logic [3:0]       w_rel_nx;
    logic [3:0]       w_cand_nx;
    logic             w_accept;
    logic             w_release;

    assign w_sample = r_run && (r_div == DIV_W'(SCAN_DIV - 1));
    assign key_col  = r_run ? ~(4'b0001 << r_col) : 4'b1111;

    // Frame map including the column being sampled this cycle.
    always_comb begin
        w_map = r_map;
        for (int r = 0; r < 4; r++) begin
            if (!key_row[r]) w_map[r*4 + int'(r_col)] = 1'b1;
        end
        w_nbits = '0;
        w_code  = '0;
        for (int i = 0; i < 16; i++) begin
            w_nbits = w_nbits + 5'(w_map[i]);
        end
        for (int i = 15; i >= 0; i--) begin
            if (w_map[i]) w_code = 4'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run        <= 1'b0;
            r_div        <= '0;
            r_col        <= '0;
            r_map        <= '0;
            r_frame_done <= 1'b0;
            r_cls        <= C_NONE;
            r_cls_code   <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (!r_run) begin
                r_run <= 1'b1;
            end else if (w_sample) begin
                r_div <= '0;
                r_col <= r_col + 2'd1;
                if (r_col == 2'd3) begin
                    r_frame_done <= 1'b1;
                    r_cls        <= (w_nbits == 5'd0) ? C_NONE :
                                    (w_nbits == 5'd1) ? C_ONE : C_MULTI;
                    r_cls_code   <= w_code;
                    r_map        <= '0;
                end else begin
                    r_map <= w_map;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_match_cnt <= '0;
            r_rel_cnt   <= '0;
            r_cand      <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_match_cnt <= w_match_nx;
            r_rel_cnt   <= w_rel_nx;
            r_cand      <= w_cand_nx;
        end
    end

    // The FSM only moves on the cycle after a frame has been classified.
    always_comb begin
        w_state_nx = r_state;
        w_match_nx = r_match_cnt;
        w_rel_nx   = r_rel_cnt;
        w_cand_nx  = r_cand;
        w_accept   = 1'b0;
        w_release  = 1'b0;
        if (r_frame_done) begin
            case (r_state)
                S_IDLE: begin
                    if (r_cls == C_ONE) begin
                        w_cand_nx  = r_cls_code;
                        w_match_nx = 4'd1;
                        if (DEBOUNCE_CNT == 1) begin
                            w_accept   = 1'b1;
                            w_state_nx = S_PRESSED;
                        end else begin
                            w_state_nx = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (r_cls != C_ONE) begin
                        w_match_nx = '0;
                        w_state_nx = S_IDLE;
                    end else if (r_cls_code != r_cand) begin
                        w_cand_nx  = r_cls_code;
                        w_match_nx = 4'd1;
                    end else begin
                        w_match_nx = r_match_cnt + 4'd1;
                        if (r_match_cnt + 4'd1 >= DB_MAX) begin
                            w_accept   = 1'b1;
                            w_state_nx = S_PRESSED;
                        end
                    end
                end
                S_PRESSED: begin
                    if (r_cls == C_NONE) begin
                        w_rel_nx = 4'd1;
                        if (DEBOUNCE_CNT == 1) begin
                            w_release  = 1'b1;
                            w_state_nx = S_IDLE;
                        end else begin
                            w_state_nx = S_RELEASE;
                        end
                    end
                end
                default: begin
                    if (r_cls != C_NONE) begin
                        w_rel_nx   = '0;
                        w_state_nx = S_PRESSED;
                    end else if (r_rel_cnt + 4'd1 >= DB_MAX) begin
                        w_rel_nx   = '0;
                        w_release  = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_rel_nx = r_rel_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // A new accept beats a same-edge read; overrun only when an unread code is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_key_code  <= '0;
            r_key_down  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_key_code  <= r_cls_code;
                r_key_valid <= 1'b1;
                r_overrun   <= r_key_valid && !io_rd_en;
            end else if (io_rd_en && r_key_valid) begin
                r_key_valid <= 1'b0;
                r_overrun   <= 1'b0;
            end
            if (w_accept) begin
                r_key_down <= 1'b1;
            end else if (w_release) begin
                r_key_down <= 1'b0;
            end
        end
    end

    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_down    = r_key_down;
    assign o_dbg_state = r_state;
    assign io_rd_data  = {r_key_valid, 22'b0, r_overrun, 4'b0, r_key_code};

endmodule

// File: tb/tb_input_ctrl_keypad.sv
// Bench for input_ctrl_keypad: behavioural 4x4 matrix, accept scoreboard,
// exact-latency checks on an aligned frame, reset-in-debounce.
module tb_input_ctrl_keypad;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic        io_rd_en;
  logic [31:0] io_rd_data;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [1:0]  dbg_state;

  logic [15:0] tb_keys;
  logic [3:0]  exp_q[$];
  logic        prev_down;
  int          n_checks;
  int          n_errors;

  input_ctrl_keypad #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_row     (key_row),
    .key_col     (key_col),
    .io_rd_en    (io_rd_en),
    .io_rd_data  (io_rd_data),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_down    (key_down),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // switch matrix: a closed key pulls its row low while its column is driven
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (tb_keys[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted press is a rising key_down
  always @(negedge clk) begin
    if (rst_n && key_down && !prev_down) begin
      if (exp_q.size() == 0) chk("accept_unexpected", 32'd1, 32'd0);
      else chk("accept_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
    end
    prev_down <= key_down;
  end

  // driver tasks
  task automatic align_frame();
    int n = 0;
    while (key_col != 4'b0111 && n < 100) begin @(negedge clk); n++; end
    while (key_col != 4'b1110 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("align_timeout", 32'd1, 32'd0);
  endtask

  task automatic hold(input int frames);
    repeat (16 * frames) @(negedge clk);
  endtask

  task automatic cpu_read();
    io_rd_en = 1'b1;
    @(negedge clk);
    io_rd_en = 1'b0;
  endtask

  task automatic press_accept(input int code);
    align_frame();
    exp_q.push_back(4'(code));
    tb_keys = 16'(1 << code);
    hold(4);
    tb_keys = '0;
    hold(4);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    io_rd_en = 1'b0;
    tb_keys  = '0;
    prev_down = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", {28'd0, key_col}, 32'h0000000F);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_rd_data", io_rd_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("scan_first_col", {28'd0, key_col}, 32'h0000000E);
    for (int i = 1; i <= 5; i++) begin
      logic [3:0] one_hot;
      repeat (4) @(negedge clk);
      one_hot = 4'(1 << (i % 4));
      chk("scan_rotate", {28'd0, key_col}, {28'd0, ~one_hot});
    end
    chk("scan_valid", {31'd0, key_valid}, 32'd0);

    // key at row 2 column 1: exact accept latency
    align_frame();
    exp_q.push_back(4'd9);
    tb_keys = 16'(1 << 9);
    repeat (48) @(negedge clk);
    chk("lat_before", {31'd0, key_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, key_valid}, 32'd1);
    chk("lat_rd_data", io_rd_data, 32'h80000009);
    chk("lat_down", {31'd0, key_down}, 32'd1);
    repeat (80 - 49) @(negedge clk);
    cpu_read();
    chk("read_rd_data", io_rd_data, 32'h00000009);
    chk("read_down", {31'd0, key_down}, 32'd1);
    tb_keys = '0;
    hold(4);
    chk("release_down", {31'd0, key_down}, 32'd0);
    chk("release_state", {30'd0, dbg_state}, 32'd0);

    // bounce: 2 frames, 1 frame open, 3 frames
    align_frame();
    tb_keys = 16'(1 << 6);
    hold(2);
    chk("bounce_no_accept", {31'd0, key_down}, 32'd0);
    tb_keys = '0;
    hold(1);
    exp_q.push_back(4'd6);
    tb_keys = 16'(1 << 6);
    hold(3);
    @(negedge clk);
    chk("bounce_accept", {31'd0, key_down}, 32'd1);
    chk("bounce_code", {28'd0, key_code}, 32'd6);
    tb_keys = '0;
    hold(4);
    cpu_read();

    // overrun: two accepts with no read in between
    press_accept(5);
    press_accept(10);
    chk("ovr_rd_data", io_rd_data, 32'h8000010A);
    chk("ovr_code", {28'd0, key_code}, 32'h0000000A);
    cpu_read();
    chk("ovr_cleared", io_rd_data, 32'h0000000A);

    // two keys at once never accept
    align_frame();
    tb_keys = 16'h8001;
    hold(5);
    chk("multi_down", {31'd0, key_down}, 32'd0);
    chk("multi_valid", {31'd0, key_valid}, 32'd0);
    chk("multi_state", {30'd0, dbg_state}, 32'd0);
    tb_keys = '0;
    hold(1);

    // reset while debouncing, with an unread key held
    press_accept(12);
    chk("pre_rst_valid", {31'd0, key_valid}, 32'd1);
    align_frame();
    tb_keys = 16'(1 << 3);
    hold(2);
    @(negedge clk);
    chk("dbn_state", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_col", {28'd0, key_col}, 32'h0000000F);
    chk("arst_rd_data", io_rd_data, 32'd0);
    chk("arst_down", {31'd0, key_down}, 32'd0);
    chk("arst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'd3);
    repeat (49) @(negedge clk);
    chk("post_rst_before", {31'd0, key_down}, 32'd0);
    @(negedge clk);
    chk("post_rst_down", {31'd0, key_down}, 32'd1);
    chk("post_rst_rd", io_rd_data, 32'h80000003);
    tb_keys = '0;
    hold(4);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
